// File: rtl/inst_fetch_pair_queue.sv
// Fetch stage feeding decode: streams aligned 8-byte pairs from local store into a
// small credit-controlled FIFO and redirects on branch_taken/flush.
module inst_fetch_pair_queue #(
    parameter int                   LS_ADDR_W = 15,
    parameter int                   DEPTH     = 4,
    parameter logic [LS_ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]          NOP_INST  = 32'h0020_0000
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 ls_rd_en,
    output logic [LS_ADDR_W-1:0] ls_rd_addr,
    input  logic [63:0]          ls_rd_data,
    input  logic                 branch_taken,
    input  logic                 flush,
    input  logic [LS_ADDR_W-1:0] branch_target,
    input  logic                 stall,
    output logic [31:0]          first_inst_output,
    output logic [31:0]          second_inst_output,
    output logic [LS_ADDR_W-1:0] pc_output,
    output logic                 inst_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);
    localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(DEPTH);
    localparam logic [LS_ADDR_W-1:0] PAIR_BYTES = LS_ADDR_W'(8);

    logic [LS_ADDR_W-1:0] fetch_pc;
    logic [LS_ADDR_W-1:0] resp_pc;
    logic                 inflight;
    logic                 drop_flag;
    logic                 odd_flag;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [CW-1:0]        count;

    logic [31:0]          q_first  [DEPTH];
    logic [31:0]          q_second [DEPTH];
    logic [LS_ADDR_W-1:0] q_pc     [DEPTH];

    logic                 redirect;
    logic                 push;
    logic                 pop;
    logic [CW:0]          credits_used;
    logic [31:0]          push_first;
    logic                 unused_target_bits;

    assign redirect     = branch_taken | flush;
    assign credits_used = {1'b0, count} + {{CW{1'b0}}, inflight};

    // Gated with reset so no request escapes while the block is held in reset.
    assign ls_rd_en   = reset & ~redirect & (credits_used < CREDIT_LIMIT);
    assign ls_rd_addr = fetch_pc;

    assign inst_valid         = (count != '0);
    assign first_inst_output  = q_first[rd_ptr];
    assign second_inst_output = q_second[rd_ptr];
    assign pc_output          = q_pc[rd_ptr];

    assign pop  = inst_valid & ~stall & ~redirect;
    assign push = inflight & ~drop_flag & ~redirect;

    // MSB-first numbering: data bits [0:31] (the even word) sit in [63:32] here.
    assign push_first = odd_flag ? NOP_INST : ls_rd_data[63:32];

    // Sub-pair offset bits of the target carry no meaning for a pair fetch.
    assign unused_target_bits = ^branch_target[1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            resp_pc   <= '0;
            inflight  <= 1'b0;
            drop_flag <= 1'b0;
            odd_flag  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            inflight <= ls_rd_en;
            if (ls_rd_en) begin
                resp_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc  <= {branch_target[LS_ADDR_W-1:3], 3'b000};
                odd_flag  <= branch_target[2];
                drop_flag <= ls_rd_en;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
            end else begin
                drop_flag <= 1'b0;
                if (ls_rd_en) begin
                    fetch_pc <= fetch_pc + PAIR_BYTES;
                end
                if (push) begin
                    wr_ptr   <= wr_ptr + PW'(1);
                    odd_flag <= 1'b0;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage is cleared on reset so the head outputs read 0 while held in reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_first[i]  <= '0;
                q_second[i] <= '0;
                q_pc[i]     <= '0;
            end
        end else if (push) begin
            q_first[wr_ptr]  <= push_first;
            q_second[wr_ptr] <= ls_rd_data[31:0];
            q_pc[wr_ptr]     <= resp_pc;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(push && !pop && (count == FULL_COUNT)));

    a_pair_aligned: assert property (@(posedge clock) disable iff (!reset)
        ls_rd_en |-> (ls_rd_addr[2:0] == 3'b000));

endmodule

// File: tb/tb_inst_fetch_pair_queue.sv
// Self-checking bench for inst_fetch_pair_queue: cycle tables for start-up and stall,
// hand sequences for redirects, wrap and mid-stream reset, plus an in-order pair scoreboard.
module tb_inst_fetch_pair_queue;

    localparam int          AW  = 15;
    localparam int          DEP = 4;
    localparam logic [31:0] NOP = 32'h0020_0000;

    logic          clock;
    logic          reset;
    logic          ls_rd_en;
    logic [AW-1:0] ls_rd_addr;
    logic [63:0]   ls_rd_data;
    logic          branch_taken;
    logic          flush;
    logic [AW-1:0] branch_target;
    logic          stall;
    logic [31:0]   first_inst_output;
    logic [31:0]   second_inst_output;
    logic [AW-1:0] pc_output;
    logic          inst_valid;

    inst_fetch_pair_queue #(
        .LS_ADDR_W(AW),
        .DEPTH    (DEP),
        .RESET_PC ('0),
        .NOP_INST (NOP)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .ls_rd_en          (ls_rd_en),
        .ls_rd_addr        (ls_rd_addr),
        .ls_rd_data        (ls_rd_data),
        .branch_taken      (branch_taken),
        .flush             (flush),
        .branch_target     (branch_target),
        .stall             (stall),
        .first_inst_output (first_inst_output),
        .second_inst_output(second_inst_output),
        .pc_output         (pc_output),
        .inst_valid        (inst_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Local store model: word at byte address a holds a/4; one-cycle read latency.
    always @(posedge clock) begin
        if (ls_rd_en) begin
            ls_rd_data <= {32'(ls_rd_addr >> 2), 32'(ls_rd_addr >> 2) + 32'd1};
        end
    end

    typedef struct {
        logic [31:0]   first;
        logic [31:0]   second;
        logic [AW-1:0] pc;
    } pair_t;

    typedef struct {
        logic          stall;
        logic          exp_en;
        logic [AW-1:0] exp_addr;
        logic          exp_valid;
        logic [31:0]   exp_first;
        logic [31:0]   exp_second;
        logic [AW-1:0] exp_pc;
    } vec_t;

    pair_t sb[$];
    vec_t  vt[15];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_from(input logic [AW-1:0] tgt, input int n);
        logic [AW-1:0] pc;
        pair_t e;
        pc = tgt & 15'h7FF8;
        sb.delete();
        for (int k = 0; k < n; k++) begin
            e.pc     = pc;
            e.first  = (k == 0 && tgt[2]) ? NOP : 32'(pc >> 2);
            e.second = 32'(pc >> 2) + 32'd1;
            sb.push_back(e);
            pc = pc + 15'd8;
        end
    endtask

    // Compares every pair decode actually accepts against the scoreboard head.
    task automatic monitor();
        pair_t e;
        if (reset && inst_valid && !stall && !(branch_taken || flush)) begin
            if (sb.size() == 0) begin
                check("unexpected_pair", {32'd0, first_inst_output}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("sb_pair", {first_inst_output, second_inst_output},
                      {e.first, e.second});
                check("sb_pc", 64'(pc_output), 64'(e.pc));
            end
        end
    endtask

    task automatic sample();
        @(negedge clock);
        monitor();
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    task automatic redirect_seq(input logic use_flush, input logic [AW-1:0] tgt);
        logic [AW-1:0] base;
        logic [AW-1:0] nxt;
        base = tgt & 15'h7FF8;
        nxt  = base + 15'd8;
        expect_from(tgt, 64);
        branch_taken  = ~use_flush;
        flush         = use_flush;
        branch_target = tgt;
        sample();
        check("redir_t_en", 64'(ls_rd_en), 64'd0);
        advance();
        branch_taken = 1'b0;
        flush        = 1'b0;
        sample();
        check("redir_t1_en", 64'(ls_rd_en), 64'd1);
        check("redir_t1_addr", 64'(ls_rd_addr), 64'(base));
        check("redir_t1_valid", 64'(inst_valid), 64'd0);
        advance();
        sample();
        check("redir_t2_valid", 64'(inst_valid), 64'd0);
        check("redir_t2_addr", 64'(ls_rd_addr), 64'(nxt));
        advance();
        sample();
        check("redir_t3_valid", 64'(inst_valid), 64'd1);
        check("redir_t3_pair", {first_inst_output, second_inst_output},
              {(tgt[2] ? NOP : 32'(base >> 2)), 32'(base >> 2) + 32'd1});
        check("redir_t3_pc", 64'(pc_output), 64'(base));
        advance();
        sample();
        check("redir_t4_pair", {first_inst_output, second_inst_output},
              {32'(nxt >> 2), 32'(nxt >> 2) + 32'd1});
        check("redir_t4_pc", 64'(pc_output), 64'(nxt));
        advance();
    endtask

    initial begin
        reset         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        flush         = 1'b0;
        branch_target = '0;

        // Start-up from RESET_PC, then DEPTH-limited fill under a 10-cycle stall.
        vt[0] = '{1'b0, 1'b1, 15'd0,  1'b0, 32'd0, 32'd0, 15'd0};
        vt[1] = '{1'b0, 1'b1, 15'd8,  1'b0, 32'd0, 32'd0, 15'd0};
        vt[2] = '{1'b0, 1'b1, 15'd16, 1'b1, 32'd0, 32'd1, 15'd0};
        vt[3] = '{1'b0, 1'b1, 15'd24, 1'b1, 32'd2, 32'd3, 15'd8};
        vt[4] = '{1'b0, 1'b1, 15'd32, 1'b1, 32'd4, 32'd5, 15'd16};
        vt[5] = '{1'b1, 1'b1, 15'd40, 1'b1, 32'd6, 32'd7, 15'd24};
        vt[6] = '{1'b1, 1'b1, 15'd48, 1'b1, 32'd6, 32'd7, 15'd24};
        for (int i = 7; i < 15; i++) begin
            vt[i] = '{1'b1, 1'b0, 15'd56, 1'b1, 32'd6, 32'd7, 15'd24};
        end

        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_en", 64'(ls_rd_en), 64'd0);
        check("rst_pair", {first_inst_output, second_inst_output}, 64'd0);
        check("rst_pc", 64'(pc_output), 64'd0);

        expect_from('0, 64);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            stall = vt[i].stall;
            sample();
            check($sformatf("vec%0d_en", i), 64'(ls_rd_en), 64'(vt[i].exp_en));
            check($sformatf("vec%0d_addr", i), 64'(ls_rd_addr), 64'(vt[i].exp_addr));
            check($sformatf("vec%0d_valid", i), 64'(inst_valid), 64'(vt[i].exp_valid));
            if (vt[i].exp_valid) begin
                check($sformatf("vec%0d_pair", i), {first_inst_output, second_inst_output},
                      {vt[i].exp_first, vt[i].exp_second});
                check($sformatf("vec%0d_pc", i), 64'(pc_output), 64'(vt[i].exp_pc));
            end
            advance();
        end

        // Stall released: buffered pairs drain back-to-back, stream continues unbroken.
        stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sample();
            check("drain_valid", 64'(inst_valid), 64'd1);
            advance();
        end

        redirect_seq(1'b0, 15'h0040);
        redirect_seq(1'b1, 15'h0044);
        redirect_seq(1'b0, 15'h7FF8);

        // Fill the queue, then branch in the same cycle decode would pop.
        stall = 1'b1;
        repeat (6) begin
            sample();
            advance();
        end
        sample();
        check("full_valid", 64'(inst_valid), 64'd1);
        check("full_en", 64'(ls_rd_en), 64'd0);
        advance();
        expect_from(15'h0100, 64);
        stall         = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 15'h0100;
        sample();
        check("brpop_valid_before", 64'(inst_valid), 64'd1);
        advance();
        branch_taken = 1'b0;
        sample();
        check("brpop_cleared", 64'(inst_valid), 64'd0);
        advance();
        repeat (3) begin
            sample();
            advance();
        end
        sample();
        check("prerst_valid", 64'(inst_valid), 64'd1);

        // Asynchronous reset mid-stream, with a read still returning during reset.
        advance();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_valid", 64'(inst_valid), 64'd0);
        check("midrst_en", 64'(ls_rd_en), 64'd0);
        check("midrst_pc", 64'(pc_output), 64'd0);
        advance();
        advance();
        expect_from('0, 64);
        reset = 1'b1;
        sample();
        check("restart_c1_en", 64'(ls_rd_en), 64'd1);
        check("restart_c1_addr", 64'(ls_rd_addr), 64'd0);
        check("restart_c1_valid", 64'(inst_valid), 64'd0);
        advance();
        sample();
        check("restart_c2_valid", 64'(inst_valid), 64'd0);
        advance();
        sample();
        check("restart_c3_valid", 64'(inst_valid), 64'd1);
        check("restart_c3_pc", 64'(pc_output), 64'd0);
        advance();
        repeat (4) begin
            sample();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
